// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: FSM state codes, interval
// register select codes and the {R,Y,G} lamp encodings.
package traffic_pkg;

    typedef enum logic [2:0] {
        GREEN_BASE = 3'd0,
        GREEN_EXT  = 3'd1,
        YELLOW     = 3'd2,
        ALL_RED    = 3'd3,
        WALK       = 3'd4
    } state_e;

    localparam logic [2:0] SEL_BASE   = 3'd0;
    localparam logic [2:0] SEL_EXT    = 3'd1;
    localparam logic [2:0] SEL_YELLOW = 3'd2;
    localparam logic [2:0] SEL_ALLRED = 3'd3;
    localparam logic [2:0] SEL_WALK   = 3'd4;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic is_green(input state_e s);
        return (s == GREEN_BASE) || (s == GREEN_EXT);
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Down-counting interval timer: load takes priority, otherwise counts down
// and holds at zero; expired is high while the count is zero.
module interval_timer #(
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase round-robin intersection controller with demand latching, one green
// extension, pedestrian walk and runtime intervals. Macro: EMERGENCY_PREEMPT_EN.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16,
    parameter int T_BASE     = 16,
    parameter int T_EXT      = 8,
    parameter int T_YELLOW   = 4,
    parameter int T_ALLRED   = 2,
    parameter int T_WALK     = 8,
    localparam int PH_W      = $clog2(NUM_PHASES)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_PHASES-1:0]   sensor,
    input  logic                    walk_req,
    input  logic                    prog_en,
    input  logic [2:0]              prog_sel,
    input  logic [CNT_W-1:0]        prog_val,
    input  logic                    preempt,
    input  logic [PH_W-1:0]         preempt_phase,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic                    walk,
    output logic                    walk_ack,
    output logic [PH_W-1:0]         phase,
    output logic [2:0]              state
);

    state_e                  state_q, nxt_state;
    logic [PH_W-1:0]         phase_q, nxt_phase;
    logic [NUM_PHASES-1:0]   demand_q, clr_mask;
    logic                    walk_pend_q, walked_q;
    logic                    load, enter_walk, timer_expired, prog_valid;
    logic [CNT_W-1:0]        load_ival, unused_count;
    logic [CNT_W-1:0]        t_base_q, t_ext_q, t_yellow_q, t_allred_q, t_walk_q;

    // A programmed interval of 0 behaves as 1 cycle.
    function automatic logic [CNT_W-1:0] to_count(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // First phase after cur (wrapping) with latched demand; phase 0 always qualifies.
    function automatic logic [PH_W-1:0] pick_next(input logic [PH_W-1:0]       cur,
                                                  input logic [NUM_PHASES-1:0] dem);
        logic [PH_W-1:0] res;
        logic            found;
        int              idx;
        res   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            idx = (int'(cur) + i) % NUM_PHASES;
            if (!found && (idx == 0 || dem[idx])) begin
                res   = PH_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3*NUM_PHASES-1:0] decode_lamps(input state_e          s,
                                                             input logic [PH_W-1:0] p);
        logic [3*NUM_PHASES-1:0] res;
        logic [2:0]              lamp;
        res = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            lamp = LAMP_R;
            if (i == int'(p)) begin
                if (is_green(s))      lamp = LAMP_G;
                else if (s == YELLOW) lamp = LAMP_Y;
            end
            res[3*i +: 3] = lamp;
        end
        return res;
    endfunction

    assign prog_valid = prog_en && (prog_sel <= SEL_WALK);

    // prog_en is a single-cycle strobe with no ready/back-pressure: the write
    // and the forced ALL_RED on phase 0 both land on the next clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t_base_q   <= CNT_W'(T_BASE);
            t_ext_q    <= CNT_W'(T_EXT);
            t_yellow_q <= CNT_W'(T_YELLOW);
            t_allred_q <= CNT_W'(T_ALLRED);
            t_walk_q   <= CNT_W'(T_WALK);
        end else if (prog_en) begin
            case (prog_sel)
                SEL_BASE:   t_base_q   <= prog_val;
                SEL_EXT:    t_ext_q    <= prog_val;
                SEL_YELLOW: t_yellow_q <= prog_val;
                SEL_ALLRED: t_allred_q <= prog_val;
                SEL_WALK:   t_walk_q   <= prog_val;
                default:    ;
            endcase
        end
    end

    always_comb begin
        nxt_state = state_q;
        nxt_phase = phase_q;
        load      = 1'b0;
        load_ival = t_base_q;
        if (prog_valid) begin
            nxt_state = ALL_RED;
            nxt_phase = '0;
            load      = 1'b1;
            load_ival = (prog_sel == SEL_ALLRED) ? prog_val : t_allred_q;
        end
`ifdef EMERGENCY_PREEMPT_EN
        else if (preempt && is_green(state_q) && phase_q != preempt_phase) begin
            nxt_state = YELLOW;
            load      = 1'b1;
            load_ival = t_yellow_q;
        end else if (preempt && timer_expired) begin
            load = 1'b1;
            case (state_q)
                GREEN_BASE, GREEN_EXT: begin
                    nxt_state = GREEN_BASE;
                    load_ival = t_base_q;
                end
                YELLOW: begin
                    nxt_state = ALL_RED;
                    load_ival = t_allred_q;
                end
                default: begin
                    nxt_state = GREEN_BASE;
                    nxt_phase = preempt_phase;
                    load_ival = t_base_q;
                end
            endcase
        end
`endif
        else if (timer_expired) begin
            load = 1'b1;
            case (state_q)
                GREEN_BASE: begin
                    if (sensor[phase_q]) begin
                        nxt_state = GREEN_EXT;
                        load_ival = t_ext_q;
                    end else if (phase_q == '0 && demand_q[NUM_PHASES-1:1] == '0) begin
                        nxt_state = GREEN_BASE;
                        load_ival = t_base_q;
                    end else begin
                        nxt_state = YELLOW;
                        load_ival = t_yellow_q;
                    end
                end
                GREEN_EXT: begin
                    nxt_state = YELLOW;
                    load_ival = t_yellow_q;
                end
                YELLOW, WALK: begin
                    nxt_state = ALL_RED;
                    load_ival = t_allred_q;
                end
                ALL_RED: begin
                    if (walk_pend_q && !walked_q) begin
                        nxt_state = WALK;
                        load_ival = t_walk_q;
                    end else begin
                        nxt_state = GREEN_BASE;
                        nxt_phase = pick_next(phase_q, demand_q);
                        load_ival = t_base_q;
                    end
                end
                default: begin
                    nxt_state = ALL_RED;
                    load_ival = t_allred_q;
                end
            endcase
        end
    end

`ifndef EMERGENCY_PREEMPT_EN
    logic unused_preempt;
    assign unused_preempt = preempt ^ (^preempt_phase);
`endif

    assign enter_walk = load && (nxt_state == WALK);
    assign clr_mask   = (load && nxt_state == GREEN_BASE) ? (NUM_PHASES'(1) << nxt_phase) : '0;

    interval_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (CNT_W'(T_BASE > 1 ? T_BASE - 1 : 0))
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (to_count(load_ival)),
        .count    (unused_count),
        .expired  (timer_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= GREEN_BASE;
            phase_q     <= '0;
            demand_q    <= '0;
            walk_pend_q <= 1'b0;
            walked_q    <= 1'b0;
            lights      <= decode_lamps(GREEN_BASE, '0);
            walk        <= 1'b0;
            walk_ack    <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            phase_q     <= nxt_phase;
            // New requests win over a same-cycle clear.
            demand_q    <= (demand_q & ~clr_mask) | sensor;
            walk_pend_q <= walk_req | (walk_pend_q & ~enter_walk);
            if (load && nxt_state == GREEN_BASE)
                walked_q <= 1'b0;
            else if (load && state_q == WALK && nxt_state != WALK)
                walked_q <= 1'b1;
            lights      <= decode_lamps(nxt_state, nxt_phase);
            walk        <= (nxt_state == WALK);
            walk_ack    <= enter_walk;
        end
    end

    assign phase = phase_q;
    assign state = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: directed scenarios push
// expected output transitions; a forked monitor checks each one as it appears.
module tb_traffic_phase_controller;

    localparam logic [2:0] S_GB = 3'd0, S_EXT = 3'd1, S_Y = 3'd2, S_AR = 3'd3, S_WALK = 3'd4;
    localparam logic [11:0] L_G0 = 12'b100_100_100_001;
    localparam logic [11:0] L_Y0 = 12'b100_100_100_010;
    localparam logic [11:0] L_G1 = 12'b100_100_001_100;
    localparam logic [11:0] L_Y1 = 12'b100_100_010_100;
    localparam logic [11:0] L_G2 = 12'b100_001_100_100;
    localparam logic [11:0] L_Y2 = 12'b100_010_100_100;
    localparam logic [11:0] L_G3 = 12'b001_100_100_100;
    localparam logic [11:0] L_Y3 = 12'b010_100_100_100;
    localparam logic [11:0] L_AR = 12'b100_100_100_100;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  sensor;
    logic        walk_req, prog_en, preempt;
    logic [2:0]  prog_sel;
    logic [15:0] prog_val;
    logic [1:0]  preempt_phase;
    logic [11:0] lights;
    logic        walk, walk_ack;
    logic [1:0]  phase;
    logic [2:0]  state;

    int          cyc;
    int          n_tests, n_fail, ack_cnt, walk_cnt;
    logic        mon_en;
    logic [34:0] exp_q[$];

    traffic_phase_controller dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sensor        (sensor),
        .walk_req      (walk_req),
        .prog_en       (prog_en),
        .prog_sel      (prog_sel),
        .prog_val      (prog_val),
        .preempt       (preempt),
        .preempt_phase (preempt_phase),
        .lights        (lights),
        .walk          (walk),
        .walk_ack      (walk_ack),
        .phase         (phase),
        .state         (state)
    );

    // Clock / reset-relative cycle counter: cycle 0 is the first cycle after release.
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_ev(input int c, input logic [2:0] st, input logic [1:0] ph,
                           input logic [11:0] lt, input logic wk, input logic ack);
        logic [15:0] c16;
        c16 = c[15:0];
        exp_q.push_back({c16, st, ph, lt, wk, ack});
    endtask

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (cyc < c) check("wait_timeout", cyc, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},    state,    S_GB);
        check({tag, "_phase"},    phase,    2'd0);
        check({tag, "_lights"},   lights,   L_G0);
        check({tag, "_walk"},     walk,     1'b0);
        check({tag, "_walk_ack"}, walk_ack, 1'b0);
    endtask

    task automatic reset_dut(input string tag);
        mon_en        = 1'b0;
        sensor        = '0;
        walk_req      = 1'b0;
        prog_en       = 1'b0;
        prog_sel      = '0;
        prog_val      = '0;
        preempt       = 1'b0;
        preempt_phase = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check_reset_outputs(tag);
        exp_q.delete();
        ack_cnt  = 0;
        walk_cnt = 0;
        mon_en   = 1'b1;
    endtask

    task automatic end_test(input string tag);
        check({tag, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        ack_cnt  = 0;
        walk_cnt = 0;
        mon_en   = 1'b0;

        fork
            begin : monitor
                logic [17:0] key, prv_key;
                logic [34:0] act, want;
                prv_key = '0;
                forever begin
                    @(negedge clock);
                    key = {state, phase, lights, walk};
                    if (mon_en && key != prv_key) begin
                        act = {cyc[15:0], state, phase, lights, walk, walk_ack};
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_change: cyc=%0d st=%0d ph=%0d lights=%b walk=%b, none expected",
                                     cyc, state, phase, lights, walk);
                        end else begin
                            want = exp_q.pop_front();
                            if (act !== want) begin
                                n_fail++;
                                $display("FAIL event: got cyc=%0d st=%0d ph=%0d lights=%b walk=%b ack=%b, expected cyc=%0d st=%0d ph=%0d lights=%b walk=%b ack=%b",
                                         act[34:19], act[18:16], act[15:14], act[13:2], act[1], act[0],
                                         want[34:19], want[18:16], want[15:14], want[13:2], want[1], want[0]);
                            end
                        end
                    end
                    if (mon_en && walk_ack) ack_cnt++;
                    if (mon_en && walk)     walk_cnt++;
                    prv_key = key;
                end
            end
        join_none

        // 1: idle rests in phase 0; sensor[0] on the third base expiry extends.
        reset_dut("t1_reset");
        push_ev(48, S_EXT, 2'd0, L_G0, 1'b0, 1'b0);
        push_ev(56, S_Y,   2'd0, L_Y0, 1'b0, 1'b0);
        push_ev(60, S_AR,  2'd0, L_AR, 1'b0, 1'b0);
        push_ev(62, S_GB,  2'd0, L_G0, 1'b0, 1'b0);
        wait_cyc(47); sensor[0] = 1'b1;
        wait_cyc(48); sensor[0] = 1'b0;
        wait_cyc(70);
        end_test("t1");

        // 2: sensor[2] pulse skips phases 1 and 3.
        reset_dut("t2_reset");
        push_ev(16, S_Y,  2'd0, L_Y0, 1'b0, 1'b0);
        push_ev(20, S_AR, 2'd0, L_AR, 1'b0, 1'b0);
        push_ev(22, S_GB, 2'd2, L_G2, 1'b0, 1'b0);
        push_ev(38, S_Y,  2'd2, L_Y2, 1'b0, 1'b0);
        push_ev(42, S_AR, 2'd2, L_AR, 1'b0, 1'b0);
        push_ev(44, S_GB, 2'd0, L_G0, 1'b0, 1'b0);
        wait_cyc(3); sensor[2] = 1'b1;
        wait_cyc(4); sensor[2] = 1'b0;
        wait_cyc(64);
        end_test("t2");

        // 3: sensor[0] held gets exactly one extension, then phase 1.
        reset_dut("t3_reset");
        sensor[0] = 1'b1;
        push_ev(16, S_EXT, 2'd0, L_G0, 1'b0, 1'b0);
        push_ev(24, S_Y,   2'd0, L_Y0, 1'b0, 1'b0);
        push_ev(28, S_AR,  2'd0, L_AR, 1'b0, 1'b0);
        push_ev(30, S_GB,  2'd1, L_G1, 1'b0, 1'b0);
        push_ev(46, S_Y,   2'd1, L_Y1, 1'b0, 1'b0);
        push_ev(50, S_AR,  2'd1, L_AR, 1'b0, 1'b0);
        push_ev(52, S_GB,  2'd0, L_G0, 1'b0, 1'b0);
        wait_cyc(3); sensor[1] = 1'b1;
        wait_cyc(4); sensor[1] = 1'b0;
        wait_cyc(60); sensor[0] = 1'b0;
        end_test("t3");

        // 4: walk request with sensor[3].
        reset_dut("t4_reset");
        push_ev(16, S_Y,    2'd0, L_Y0, 1'b0, 1'b0);
        push_ev(20, S_AR,   2'd0, L_AR, 1'b0, 1'b0);
        push_ev(22, S_WALK, 2'd0, L_AR, 1'b1, 1'b1);
        push_ev(30, S_AR,   2'd0, L_AR, 1'b0, 1'b0);
        push_ev(32, S_GB,   2'd3, L_G3, 1'b0, 1'b0);
        wait_cyc(3); sensor[3] = 1'b1; walk_req = 1'b1;
        wait_cyc(4); sensor[3] = 1'b0; walk_req = 1'b0;
        wait_cyc(40);
        end_test("t4");
        check("t4_walk_cycles", walk_cnt, 8);
        check("t4_walk_ack_pulses", ack_cnt, 1);

        // 5: program yellow=1 mid-green; an invalid select changes nothing.
        reset_dut("t5_reset");
        push_ev(6,  S_AR, 2'd0, L_AR, 1'b0, 1'b0);
        push_ev(8,  S_GB, 2'd1, L_G1, 1'b0, 1'b0);
        push_ev(24, S_Y,  2'd1, L_Y1, 1'b0, 1'b0);
        push_ev(25, S_AR, 2'd1, L_AR, 1'b0, 1'b0);
        push_ev(27, S_GB, 2'd0, L_G0, 1'b0, 1'b0);
        wait_cyc(3);  sensor[1] = 1'b1;
        wait_cyc(4);  sensor[1] = 1'b0;
        wait_cyc(5);  prog_en = 1'b1; prog_sel = 3'd2; prog_val = 16'd1;
        wait_cyc(6);  prog_en = 1'b0;
        wait_cyc(30); prog_en = 1'b1; prog_sel = 3'd6; prog_val = 16'd5;
        wait_cyc(31); prog_en = 1'b0;
        wait_cyc(45);
        end_test("t5");

        // 6: preempt to phase 3 during phase 1 green.
        reset_dut("t6_reset");
        push_ev(16, S_Y,  2'd0, L_Y0, 1'b0, 1'b0);
        push_ev(20, S_AR, 2'd0, L_AR, 1'b0, 1'b0);
        push_ev(22, S_GB, 2'd1, L_G1, 1'b0, 1'b0);
`ifdef EMERGENCY_PREEMPT_EN
        push_ev(26, S_Y,  2'd1, L_Y1, 1'b0, 1'b0);
        push_ev(30, S_AR, 2'd1, L_AR, 1'b0, 1'b0);
        push_ev(32, S_GB, 2'd3, L_G3, 1'b0, 1'b0);
        push_ev(64, S_Y,  2'd3, L_Y3, 1'b0, 1'b0);
        push_ev(68, S_AR, 2'd3, L_AR, 1'b0, 1'b0);
        push_ev(70, S_GB, 2'd0, L_G0, 1'b0, 1'b0);
`else
        push_ev(38, S_Y,  2'd1, L_Y1, 1'b0, 1'b0);
        push_ev(42, S_AR, 2'd1, L_AR, 1'b0, 1'b0);
        push_ev(44, S_GB, 2'd0, L_G0, 1'b0, 1'b0);
`endif
        wait_cyc(3);  sensor[1] = 1'b1;
        wait_cyc(4);  sensor[1] = 1'b0;
        wait_cyc(25); preempt = 1'b1; preempt_phase = 2'd3;
        wait_cyc(60); preempt = 1'b0;
        wait_cyc(75);
        end_test("t6");

        // 6b: asynchronous reset in the middle of WALK.
        reset_dut("t6b_reset");
        push_ev(16, S_Y,    2'd0, L_Y0, 1'b0, 1'b0);
        push_ev(20, S_AR,   2'd0, L_AR, 1'b0, 1'b0);
        push_ev(22, S_WALK, 2'd0, L_AR, 1'b1, 1'b1);
        wait_cyc(3); sensor[3] = 1'b1; walk_req = 1'b1;
        wait_cyc(4); sensor[3] = 1'b0; walk_req = 1'b0;
        wait_cyc(25);
        end_test("t6b");
        check("t6b_walk_before_reset", walk, 1'b1);
        mon_en = 1'b0;
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("t6b_async");
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
